periph_bus: RTL and testbench

Memory-mapped peripheral responder on the CPU data-memory port, decoding the 0x4000_00xx window alongside data RAM. It serves rd/wr/addr/wdata/rdata accesses issued by the MEM stage. It contains an auto-reload timer with interrupt, an LED output register, a synchronized switch input and an 8N1 UART transmitter. All accesses complete in a single cycle with no wait states.

---
 rtl/periph_bus.sv | 148 ++++++++++++++
 tb/tb_periph_bus.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/periph_bus.sv
// periph_bus: single-cycle memory-mapped peripherals in the 0x4000_00xx window.
// Holds an auto-reload timer with level interrupt, an LED register, a
// two-flop synchronized switch input and an 8N1 UART transmitter.
module periph_bus #(
  parameter int BAUD_DIV = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [7:0]  switch_in,
  output logic [7:0]  led,
  output logic        txd,
  output logic        irqout
);

  // Word addresses (byte address >> 2)
  localparam logic [29:0] W_TH   = 30'h1000_0000;
  localparam logic [29:0] W_TL   = 30'h1000_0001;
  localparam logic [29:0] W_TCON = 30'h1000_0002;
  localparam logic [29:0] W_LED  = 30'h1000_0003;
  localparam logic [29:0] W_SW   = 30'h1000_0004;
  localparam logic [29:0] W_TXD  = 30'h1000_0006;
  localparam logic [29:0] W_UCON = 30'h1000_0008;

  localparam logic [15:0] DIV_LAST = 16'(BAUD_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  logic [31:0] r_th, r_tl;
  logic [2:0]  r_tcon;
  logic [7:0]  r_led, r_sw0, r_sw1;
  uart_state_t r_state;
  logic [15:0] r_div;
  logic [2:0]  r_bitcnt;
  logic [7:0]  r_shift;
  logic        r_txd, r_done;

  logic [29:0] w_word;
  logic        w_wrap, w_busy, w_tick, w_wr_txd;

  assign w_word   = addr[31:2];
  assign w_wrap   = r_tcon[0] && (r_tl == 32'hFFFF_FFFF);
  assign w_busy   = (r_state != S_IDLE);
  assign w_tick   = (r_div == DIV_LAST);
  // Writes to UART_TXD only count while idle; a busy transmitter drops them.
  assign w_wr_txd = wr && (w_word == W_TXD) && !w_busy;

  assign led    = r_led;
  assign txd    = r_txd;
  assign irqout = r_tcon[1] & r_tcon[2];

  // Timer, LED and control registers; CPU writes win over the count, but a
  // wrap in the same cycle still latches the interrupt status bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_th   <= '0;
      r_tl   <= '0;
      r_tcon <= '0;
      r_led  <= '0;
    end else begin
      if (wr && w_word == W_TH) r_th <= wdata;
      if (wr && w_word == W_TL)  r_tl <= wdata;
      else if (r_tcon[0])        r_tl <= w_wrap ? r_th : r_tl + 32'd1;
      if (wr && w_word == W_TCON) r_tcon <= wdata[2:0];
      if (w_wrap && r_tcon[1])    r_tcon[2] <= 1'b1;
      if (wr && w_word == W_LED)  r_led <= wdata[7:0];
    end
  end

  // Two-flop synchronizer for the asynchronous board switches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sw0 <= '0;
      r_sw1 <= '0;
    end else begin
      r_sw0 <= switch_in;
      r_sw1 <= r_sw0;
    end
  end

  // UART transmit FSM; every state lasts BAUD_DIV cycles, txd is registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_div    <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_txd    <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      // Write-1-to-clear first so a same-cycle completion leaves done set.
      if (wr && w_word == W_UCON && wdata[1]) r_done <= 1'b0;
      if (r_state == S_IDLE || w_tick) r_div <= '0;
      else                             r_div <= r_div + 16'd1;
      case (r_state)
        S_IDLE: begin
          r_txd <= 1'b1;
          if (w_wr_txd) begin
            r_shift <= wdata[7:0];
            r_txd   <= 1'b0;
            r_state <= S_START;
          end
        end
        S_START: if (w_tick) begin
          r_state  <= S_DATA;
          r_bitcnt <= '0;
          r_txd    <= r_shift[0];
        end
        S_DATA: if (w_tick) begin
          if (r_bitcnt == 3'd7) begin
            r_state <= S_STOP;
            r_txd   <= 1'b1;
          end else begin
            r_bitcnt <= r_bitcnt + 3'd1;
            r_shift  <= r_shift >> 1;
            r_txd    <= r_shift[1];
          end
        end
        S_STOP: if (w_tick) begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Combinational read mux; idle bus and unmapped words read zero.
  always_comb begin
    rdata = '0;
    if (rd) begin
      case (w_word)
        W_TH:    rdata = r_th;
        W_TL:    rdata = r_tl;
        W_TCON:  rdata = {29'd0, r_tcon};
        W_LED:   rdata = {24'd0, r_led};
        W_SW:    rdata = {24'd0, r_sw1};
        W_UCON:  rdata = {30'd0, r_done, w_busy};
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_periph_bus.sv
// Directed bench for periph_bus with a 4-cycle UART bit time.
module tb_periph_bus;

  localparam logic [31:0] A_TH   = 32'h4000_0000;
  localparam logic [31:0] A_TL   = 32'h4000_0004;
  localparam logic [31:0] A_TCON = 32'h4000_0008;
  localparam logic [31:0] A_LED  = 32'h4000_000C;
  localparam logic [31:0] A_SW   = 32'h4000_0010;
  localparam logic [31:0] A_TXD  = 32'h4000_0018;
  localparam logic [31:0] A_UCON = 32'h4000_0020;
  localparam logic [31:0] A_BAD  = 32'h4000_0030;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rd = 1'b0, wr = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic [7:0]  switch_in = '0;
  logic [7:0]  led;
  logic        txd, irqout;

  int n_tests = 0;
  int n_fail  = 0;

  periph_bus #(.BAUD_DIV(4)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .switch_in(switch_in), .led(led), .txd(txd), .irqout(irqout)
  );

  always #5 clk = ~clk;

  // All stimulus is applied in the low phase, right after a negedge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    rd = 1'b1; addr = a;
    #1;
    d = rdata;
    rd = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [31:0] amap [7];
    amap = '{A_TH, A_TL, A_TCON, A_LED, A_SW, A_TXD, A_UCON};
    foreach (amap[i]) begin
      bus_read(amap[i], v);
      n_tests++;
      if (v !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_read addr=%h got=%h exp=0", amap[i], v);
      end
    end
    n_tests++;
    if (txd !== 1'b1 || irqout !== 1'b0 || led !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_outputs txd=%b irq=%b led=%h exp 1/0/00", txd, irqout, led);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] v;
    bus_read(A_BAD, v);
    n_tests++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL unmapped_read got=%h exp=0", v); end
    bus_write(A_BAD, 32'hFFFF_FFFF);
    bus_read(A_TH, v);
    n_tests++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL unmapped_write_th got=%h exp=0", v); end
    bus_read(A_LED, v);
    n_tests++;
    if (v !== 32'd0 || led !== 8'h00) begin
      n_fail++; $display("FAIL unmapped_write_led got=%h led=%h exp=0", v, led);
    end
    bus_read(A_TCON, v);
    n_tests++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL unmapped_write_tcon got=%h exp=0", v); end
  endtask

  task automatic test_timer_wrap();
    logic [31:0] v;
    bus_write(A_TH, 32'hFFFF_FFF0);
    bus_write(A_TL, 32'hFFFF_FFFE);
    bus_write(A_TCON, 32'd3);
    bus_read(A_TL, v);
    n_tests++;
    if (v !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL timer_start got=%h exp=fffffffe", v); end
    tick();
    bus_read(A_TL, v);
    n_tests++;
    if (v !== 32'hFFFF_FFFF || irqout !== 1'b0) begin
      n_fail++; $display("FAIL timer_max got=%h irq=%b exp=ffffffff/0", v, irqout);
    end
    tick();
    bus_read(A_TL, v);
    n_tests++;
    if (v !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL timer_reload got=%h exp=fffffff0", v); end
    n_tests++;
    if (irqout !== 1'b1) begin n_fail++; $display("FAIL timer_irq got=%b exp=1", irqout); end
    bus_read(A_TCON, v);
    n_tests++;
    if (v !== 32'd7) begin n_fail++; $display("FAIL timer_tcon_status got=%h exp=7", v); end
    bus_write(A_TCON, 32'd3);
    n_tests++;
    if (irqout !== 1'b0) begin n_fail++; $display("FAIL timer_irq_clear got=%b exp=0", irqout); end
  endtask

  task automatic test_write_wins();
    logic [31:0] v;
    // Timer still running with TCON=3; park TL at max, then write on the wrap cycle.
    bus_write(A_TL, 32'hFFFF_FFFF);
    bus_write(A_TL, 32'd5);
    bus_read(A_TL, v);
    n_tests++;
    if (v !== 32'd5) begin n_fail++; $display("FAIL write_wins_tl got=%h exp=5", v); end
    bus_read(A_TCON, v);
    n_tests++;
    if (v !== 32'd7) begin n_fail++; $display("FAIL write_wins_status got=%h exp=7", v); end
    bus_write(A_TCON, 32'd0);
    n_tests++;
    if (irqout !== 1'b0) begin n_fail++; $display("FAIL timer_stop_irq got=%b exp=0", irqout); end
  endtask

  task automatic test_led_switch();
    logic [31:0] v;
    bus_write(A_LED, 32'hFFFF_FFA5);
    bus_read(A_LED, v);
    n_tests++;
    if (v !== 32'h0000_00A5 || led !== 8'hA5) begin
      n_fail++; $display("FAIL led got=%h led=%h exp=a5", v, led);
    end
    rd = 1'b0; addr = A_LED; #1;
    n_tests++;
    if (rdata !== 32'd0) begin n_fail++; $display("FAIL rd_low got=%h exp=0", rdata); end
    switch_in = 8'h3C;
    tick();
    bus_read(A_SW, v);
    n_tests++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL switch_early got=%h exp=0", v); end
    tick();
    bus_read(A_SW, v);
    n_tests++;
    if (v !== 32'h0000_003C) begin n_fail++; $display("FAIL switch_sync got=%h exp=3c", v); end
  endtask

  task automatic test_uart_frame();
    logic [31:0] v;
    logic [9:0]  frame;
    frame = 10'b1_01010011_0;
    bus_write(A_TXD, 32'h0000_0053);
    for (int k = 0; k < 40; k++) begin
      bus_read(A_UCON, v);
      n_tests++;
      if (txd !== frame[k/4] || v[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL uart_frame cyc=%0d txd=%b busy=%b exp=%b/1", k, txd, v[0], frame[k/4]);
      end
      tick();
    end
    bus_read(A_UCON, v);
    n_tests++;
    if (v !== 32'd2 || txd !== 1'b1) begin
      n_fail++; $display("FAIL uart_done got=%h txd=%b exp=2/1", v, txd);
    end
    bus_write(A_UCON, 32'd2);
    bus_read(A_UCON, v);
    n_tests++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL uart_done_clear got=%h exp=0", v); end
  endtask

  task automatic test_uart_busy_guard();
    logic [31:0] v;
    logic [9:0]  frame;
    frame = 10'b1_01010011_0;
    bus_write(A_TXD, 32'h0000_0053);
    for (int k = 0; k < 40; k++) begin
      n_tests++;
      if (txd !== frame[k/4]) begin
        n_fail++; $display("FAIL uart_guard cyc=%0d txd=%b exp=%b", k, txd, frame[k/4]);
      end
      if (k == 10)      bus_write(A_TXD, 32'h0000_00FF);
      else if (k == 39) bus_write(A_TXD, 32'h0000_00AA);
      else              tick();
    end
    // The write landing on the final STOP cycle must not start a new frame.
    tick();
    bus_read(A_UCON, v);
    n_tests++;
    if (v[0] !== 1'b0 || txd !== 1'b1) begin
      n_fail++; $display("FAIL uart_stop_write busy=%b txd=%b exp=0/1", v[0], txd);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] v;
    bus_write(A_TXD, 32'h0000_0053);
    repeat (13) tick();
    n_tests++;
    if (txd !== 1'b0) begin n_fail++; $display("FAIL mid_frame_pre txd=%b exp=0", txd); end
    reset = 1'b0;
    #1;
    bus_read(A_UCON, v);
    n_tests++;
    if (txd !== 1'b1 || v[0] !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_frame txd=%b busy=%b exp=1/0", txd, v[0]);
    end
    tick();
    reset = 1'b1;
  endtask

  initial begin
    repeat (2) tick();
    reset = 1'b1;
    tick();
    test_reset();
    test_unmapped();
    test_timer_wrap();
    test_write_wins();
    test_led_switch();
    test_uart_frame();
    test_uart_busy_guard();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
